// File: rtl/mips_pkg.sv
// Types and constants shared across the multicycle MIPS core.
// LATENCY_MAX is also used by the controller stall logic.
package mips_pkg;

   localparam int WORD_W      = 32;
   localparam int LATENCY_MAX = 15;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      HOLD
   } mem_state_t;

endpackage

// File: rtl/mips_word_ram.sv
// Single-port synchronous word RAM with a registered read port.
// The RAM reads the addressed word every cycle and writes it when we is high.
module mips_word_ram
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
   input  logic [WORD_W-1:0]              din,
   output logic [WORD_W-1:0]              dout
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   // NOTE: the array has no reset, so it maps onto block RAM; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (we) mem[idx] <= din;
      dout <= mem[idx];
   end

endmodule

// File: rtl/mips_mem_unit.sv
// Unified instruction/data memory for the multicycle MIPS core.
// Each accepted access completes after LATENCY wait cycles with a one-cycle ready pulse.
module mips_mem_unit
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int         IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT   = 4'(LATENCY);

   mem_state_t        state, state_nxt;
   logic [3:0]        cnt;
   logic [IDX_W-1:0]  idx_q, ram_idx;
   logic [WORD_W-1:0] wdata_q, ram_dout;
   logic              write_q, conflict_q, misalign_q;
   logic              accept, reject, ram_we, rd_done;

   // Address bits above the word index are ignored, so the address space wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[WORD_W-1:IDX_W+2];

   assign accept  = (state == IDLE) && (mem_read || mem_write);
   assign reject  = conflict_q || misalign_q;
   assign ready   = (state == DONE);
   assign err     = ready && reject;
   assign busy    = (state == BUSY) || (state == DONE);
   assign rd_done = ready && !write_q && !reject;
   // A reset landing on the DONE edge must still keep the write from committing.
   assign ram_we  = ready && write_q && !reject && !rst;
   // In IDLE the RAM looks at the live address so the word is ready even with zero latency.
   assign ram_idx = (state == IDLE) ? addr[IDX_W+1:2] : idx_q;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = (LAT == 4'd0) ? DONE : BUSY;
         BUSY: if (cnt == 4'd1) state_nxt = DONE;
         DONE: state_nxt = HOLD;
         HOLD: if (!mem_read && !mem_write) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt        <= LAT;
            idx_q      <= addr[IDX_W+1:2];
            wdata_q    <= wdata;
            write_q    <= mem_write;
            conflict_q <= mem_read && mem_write;
            misalign_q <= (addr[1:0] != 2'b00);
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (rd_done) rdata <= ram_dout;
      end
   end

   mips_word_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk (clk),
      .we  (ram_we),
      .idx (ram_idx),
      .din (wdata_q),
      .dout(ram_dout)
   );

endmodule
